// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-stream FIFO write port among N_SRC producers.
// A grant lasts until the source's tlast beat or MAX_BURST beats, whichever comes first.
module fifo_rr_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 22,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC*DATA_W-1:0]    s_tdata,
  input  logic [N_SRC-1:0]           s_tvalid,
  input  logic [N_SRC-1:0]           s_tlast,
  output logic [N_SRC-1:0]           s_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] burst_cnt;

  logic          found_hi;
  logic          found_lo;
  logic [GW-1:0] pick_hi;
  logic [GW-1:0] pick_lo;
  logic          found;
  logic [GW-1:0] pick;

  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              beat;
  logic              burst_end;

  // Round-robin pick: lowest requester above last_grant, else lowest at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int j = 0; j < N_SRC; j++) begin
      if (!found_hi && s_tvalid[j] && (GW'(j) > last_grant)) begin
        found_hi = 1'b1;
        pick_hi  = GW'(j);
      end
      if (!found_lo && s_tvalid[j] && (GW'(j) <= last_grant)) begin
        found_lo = 1'b1;
        pick_lo  = GW'(j);
      end
    end
    found = found_hi | found_lo;
    pick  = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int j = 0; j < N_SRC; j++) begin
      if (grant_id == GW'(j)) begin
        sel_data  = s_tdata[j*DATA_W +: DATA_W];
        sel_valid = s_tvalid[j];
        sel_last  = s_tlast[j];
      end
    end
  end

  // Pure pass-through while granted; everything is forced low in IDLE.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state == GRANT) begin
      m_tdata  = sel_data;
      m_tvalid = sel_valid;
      m_tlast  = sel_last;
      for (int j = 0; j < N_SRC; j++) begin
        s_tready[j] = (grant_id == GW'(j)) & m_tready;
      end
    end
  end

  assign beat      = (state == GRANT) && sel_valid && m_tready;
  assign burst_end = (burst_cnt == CW'(MAX_BURST - 1));
  assign busy      = (state == GRANT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = GRANT;
      GRANT:   if (beat && (sel_last || burst_end)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // grant_id keeps the last winner through IDLE; the counter restarts on every new grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id   <= '0;
      last_grant <= GW'(N_SRC - 1);
      burst_cnt  <= '0;
    end else if ((state == IDLE) && found) begin
      grant_id   <= pick;
      last_grant <= pick;
      burst_cnt  <= '0;
    end else if (beat) begin
      burst_cnt  <= burst_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: directed scenarios with hand-derived expectations
// plus randomized traffic checked against a behavioural reference model.
module tb_fifo_rr_arbiter;

  localparam int N_SRC     = 4;
  localparam int DATA_W    = 22;
  localparam int MAX_BURST = 8;
  localparam int GW        = $clog2(N_SRC);
  localparam int QD        = 128;
  localparam int HD        = 64;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_SRC*DATA_W-1:0] s_tdata;
  logic [N_SRC-1:0]        s_tvalid;
  logic [N_SRC-1:0]        s_tlast;
  logic [N_SRC-1:0]        s_tready;
  logic [DATA_W-1:0]       m_tdata;
  logic                    m_tvalid;
  logic                    m_tlast;
  logic                    m_tready;
  logic [GW-1:0]           grant_id;
  logic                    busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-source beat queues (data, last) consumed in order.
  logic [DATA_W-1:0] bd [N_SRC][QD];
  logic              bl [N_SRC][QD];
  int                head [N_SRC];
  int                tail [N_SRC];

  int cyc;
  int stall_lo, stall_hi, gap_src, gap_lo, gap_hi, reset_at;

  logic              busy_h [HD];
  logic [GW-1:0]     gid_h  [HD];
  logic [N_SRC-1:0]  rdy_h  [HD];
  logic              mval_h [HD];
  logic [DATA_W-1:0] mdat_h [HD];

  int                n_obs;
  int                obs_cyc  [QD];
  logic [GW-1:0]     obs_gid  [QD];
  logic [DATA_W-1:0] obs_data [QD];
  logic              obs_last [QD];

  fifo_rr_arbiter #(.N_SRC(N_SRC), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic push(input int src, input logic [DATA_W-1:0] d, input logic l);
    if (tail[src] < QD) begin
      bd[src][tail[src]] = d;
      bl[src][tail[src]] = l;
      tail[src]++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    cyc = 0; n_obs = 0;
    stall_lo = -1; stall_hi = -1;
    gap_src = -1; gap_lo = -1; gap_hi = -1;
    reset_at = -1;
    @(posedge clk);
  endtask

  // One cycle of directed traffic: drive at negedge, observe 1 ns later, pop on handshake.
  task automatic step();
    @(negedge clk);
    reset    = (cyc == reset_at);
    m_tready = !(cyc >= stall_lo && cyc <= stall_hi);
    for (int i = 0; i < N_SRC; i++) begin
      logic have;
      have = (head[i] < tail[i]) && !(i == gap_src && cyc >= gap_lo && cyc <= gap_hi);
      s_tvalid[i] = have;
      s_tdata[i*DATA_W +: DATA_W] = have ? bd[i][head[i]] : '0;
      s_tlast[i] = have ? bl[i][head[i]] : 1'b0;
    end
    #1;
    if (cyc < HD) begin
      busy_h[cyc] = busy;
      gid_h[cyc]  = grant_id;
      rdy_h[cyc]  = s_tready;
      mval_h[cyc] = m_tvalid;
      mdat_h[cyc] = m_tdata;
    end
    if (m_tvalid && m_tready && n_obs < QD) begin
      obs_cyc[n_obs]  = cyc;
      obs_gid[n_obs]  = grant_id;
      obs_data[n_obs] = m_tdata;
      obs_last[n_obs] = m_tlast;
      n_obs++;
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (s_tvalid[i] && s_tready[i]) head[i]++;
    end
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset    = 1'b1;
    s_tvalid = '1;
    s_tlast  = '1;
    m_tready = 1'b1;
    for (int i = 0; i < N_SRC; i++) s_tdata[i*DATA_W +: DATA_W] = DATA_W'(32'h2AAAA + i);
    @(posedge clk);
    #1;
    tests_run++;
    if ({busy, grant_id} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got busy=%0b grant_id=%0d, expected 0/0", busy, grant_id);
    end
    tests_run++;
    if ({m_tvalid, m_tlast, m_tdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_master: got valid=%0b last=%0b data=%h, expected all 0", m_tvalid, m_tlast, m_tdata);
    end
    tests_run++;
    if (s_tready !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_tready: got %b expected 0000", s_tready);
    end
  endtask

  task automatic test_round_robin();
    int exp_gid [10] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 0};
    int order [5] = '{0, 1, 2, 3, 0};
    logic [DATA_W-1:0] ed;
    do_reset();
    for (int s = 0; s < N_SRC; s++) push(s, DATA_W'(32'h1000 + s), 1'b1);
    push(0, DATA_W'(32'h2000), 1'b1);
    repeat (10) step();
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (busy_h[c] !== 1'(c % 2) || gid_h[c] !== GW'(exp_gid[c])) begin
        tests_failed++;
        $display("[TB] FAIL rr_cycle%0d: got busy=%0b gid=%0d, expected busy=%0d gid=%0d",
                 c, busy_h[c], gid_h[c], c % 2, exp_gid[c]);
      end
    end
    tests_run++;
    if (n_obs !== 5) begin
      tests_failed++;
      $display("[TB] FAIL rr_beats: got %0d beats expected 5", n_obs);
    end
    for (int k = 0; k < 5; k++) begin
      ed = (k == 4) ? DATA_W'(32'h2000) : DATA_W'(32'h1000 + k);
      tests_run++;
      if (k >= n_obs || obs_cyc[k] !== 2*k+1 || obs_gid[k] !== GW'(order[k]) || obs_data[k] !== ed) begin
        tests_failed++;
        $display("[TB] FAIL rr_beat%0d: got cyc=%0d gid=%0d data=%h, expected cyc=%0d gid=%0d data=%h",
                 k, obs_cyc[k], obs_gid[k], obs_data[k], 2*k+1, order[k], ed);
      end
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    push(2, DATA_W'(1), 1'b0);
    push(2, DATA_W'(2), 1'b0);
    push(2, DATA_W'(3), 1'b1);
    repeat (6) step();
    tests_run++;
    if (n_obs !== 3) begin
      tests_failed++;
      $display("[TB] FAIL pkt_beats: got %0d beats expected 3", n_obs);
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (k >= n_obs || obs_cyc[k] !== k+1 || obs_gid[k] !== GW'(2) ||
          obs_data[k] !== DATA_W'(k+1) || obs_last[k] !== 1'(k == 2)) begin
        tests_failed++;
        $display("[TB] FAIL pkt_beat%0d: got cyc=%0d gid=%0d data=%h last=%0b, expected cyc=%0d gid=2 data=%h last=%0d",
                 k, obs_cyc[k], obs_gid[k], obs_data[k], obs_last[k], k+1, k+1, k == 2);
      end
    end
    tests_run++;
    if (busy_h[4] !== 1'b0 || gid_h[4] !== GW'(2) || mval_h[4] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pkt_after: got busy=%0b gid=%0d valid=%0b, expected 0/2/0", busy_h[4], gid_h[4], mval_h[4]);
    end
  endtask

  task automatic test_burst_cap();
    int e_cyc [14];
    int e_src [14];
    logic [DATA_W-1:0] e_dat [14];
    logic e_lst [14];
    int n = 0;
    do_reset();
    for (int k = 0; k < 12; k++) push(1, DATA_W'(32'h100 + k), k == 11);
    for (int k = 0; k < 2; k++)  push(3, DATA_W'(32'h300 + k), k == 1);
    repeat (20) step();
    for (int k = 0; k < 8; k++) begin
      e_cyc[n] = k + 1; e_src[n] = 1; e_dat[n] = DATA_W'(32'h100 + k); e_lst[n] = 1'b0; n++;
    end
    for (int k = 0; k < 2; k++) begin
      e_cyc[n] = 10 + k; e_src[n] = 3; e_dat[n] = DATA_W'(32'h300 + k); e_lst[n] = (k == 1); n++;
    end
    for (int k = 8; k < 12; k++) begin
      e_cyc[n] = 5 + k; e_src[n] = 1; e_dat[n] = DATA_W'(32'h100 + k); e_lst[n] = (k == 11); n++;
    end
    tests_run++;
    if (n_obs !== n) begin
      tests_failed++;
      $display("[TB] FAIL burst_beats: got %0d beats expected %0d", n_obs, n);
    end
    for (int k = 0; k < n; k++) begin
      tests_run++;
      if (k >= n_obs || obs_cyc[k] !== e_cyc[k] || obs_gid[k] !== GW'(e_src[k]) ||
          obs_data[k] !== e_dat[k] || obs_last[k] !== e_lst[k]) begin
        tests_failed++;
        $display("[TB] FAIL burst_beat%0d: got cyc=%0d gid=%0d data=%h last=%0b, expected cyc=%0d gid=%0d data=%h last=%0b",
                 k, obs_cyc[k], obs_gid[k], obs_data[k], obs_last[k], e_cyc[k], e_src[k], e_dat[k], e_lst[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int ec;
    do_reset();
    for (int k = 0; k < 10; k++) push(0, DATA_W'(32'h10 + k), k == 9);
    stall_lo = 3;
    stall_hi = 7;
    repeat (18) step();
    for (int c = 3; c <= 7; c++) begin
      tests_run++;
      if (rdy_h[c] !== '0 || busy_h[c] !== 1'b1 || gid_h[c] !== GW'(0) || mval_h[c] !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stall_cycle%0d: got tready=%b busy=%0b gid=%0d valid=%0b, expected 0000/1/0/1",
                 c, rdy_h[c], busy_h[c], gid_h[c], mval_h[c]);
      end
    end
    tests_run++;
    if (busy_h[14] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_cap_idle: got busy=%0b at cycle 14 expected 0", busy_h[14]);
    end
    tests_run++;
    if (n_obs !== 10) begin
      tests_failed++;
      $display("[TB] FAIL stall_beats: got %0d beats expected 10", n_obs);
    end
    for (int k = 0; k < 10; k++) begin
      ec = (k < 2) ? k + 1 : ((k < 8) ? k + 6 : k + 7);
      tests_run++;
      if (k >= n_obs || obs_cyc[k] !== ec || obs_data[k] !== DATA_W'(32'h10 + k) || obs_last[k] !== 1'(k == 9)) begin
        tests_failed++;
        $display("[TB] FAIL stall_beat%0d: got cyc=%0d data=%h last=%0b, expected cyc=%0d data=%h last=%0d",
                 k, obs_cyc[k], obs_data[k], obs_last[k], ec, 32'h10 + k, k == 9);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int k = 0; k < 4; k++) push(1, DATA_W'(32'h40 + k), k == 3);
    reset_at = 2;
    repeat (3) step();
    push(0, DATA_W'(32'h50), 1'b1);
    repeat (3) step();
    tests_run++;
    if (busy_h[2] !== 1'b1 || gid_h[2] !== GW'(1)) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_before: got busy=%0b gid=%0d expected 1/1", busy_h[2], gid_h[2]);
    end
    tests_run++;
    if ({busy_h[3], gid_h[3], rdy_h[3], mval_h[3], mdat_h[3]} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_after: got busy=%0b gid=%0d tready=%b valid=%0b data=%h, expected all 0",
               busy_h[3], gid_h[3], rdy_h[3], mval_h[3], mdat_h[3]);
    end
    tests_run++;
    if (busy_h[4] !== 1'b1 || gid_h[4] !== GW'(0) || mdat_h[4] !== DATA_W'(32'h50)) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_regrant: got busy=%0b gid=%0d data=%h, expected 1/0/00050",
               busy_h[4], gid_h[4], mdat_h[4]);
    end
  endtask

  task automatic test_valid_gap();
    int e_cyc [6] = '{1, 5, 6, 7, 9, 11};
    int e_src [6] = '{3, 3, 3, 3, 0, 1};
    int e_dat [6] = '{'h30, 'h31, 'h32, 'h33, 'h60, 'h70};
    int e_lst [6] = '{0, 0, 0, 1, 1, 1};
    do_reset();
    for (int k = 0; k < 4; k++) push(3, DATA_W'(32'h30 + k), k == 3);
    gap_src = 3; gap_lo = 2; gap_hi = 4;
    repeat (2) step();
    push(0, DATA_W'(32'h60), 1'b1);
    push(1, DATA_W'(32'h70), 1'b1);
    repeat (10) step();
    for (int c = 2; c <= 4; c++) begin
      tests_run++;
      if (mval_h[c] !== 1'b0 || gid_h[c] !== GW'(3) || busy_h[c] !== 1'b1 || rdy_h[c] !== 4'b1000) begin
        tests_failed++;
        $display("[TB] FAIL gap_cycle%0d: got valid=%0b gid=%0d busy=%0b tready=%b, expected 0/3/1/1000",
                 c, mval_h[c], gid_h[c], busy_h[c], rdy_h[c]);
      end
    end
    tests_run++;
    if (n_obs !== 6) begin
      tests_failed++;
      $display("[TB] FAIL gap_beats: got %0d beats expected 6", n_obs);
    end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (k >= n_obs || obs_cyc[k] !== e_cyc[k] || obs_gid[k] !== GW'(e_src[k]) ||
          obs_data[k] !== DATA_W'(e_dat[k]) || obs_last[k] !== 1'(e_lst[k])) begin
        tests_failed++;
        $display("[TB] FAIL gap_beat%0d: got cyc=%0d gid=%0d data=%h last=%0b, expected cyc=%0d gid=%0d data=%h last=%0d",
                 k, obs_cyc[k], obs_gid[k], obs_data[k], obs_last[k], e_cyc[k], e_src[k], e_dat[k], e_lst[k]);
      end
    end
  endtask

  // Random traffic: the model tracks only "who holds the grant and how many beats it has used".
  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      bit                mg;
      logic [GW-1:0]     mgid;
      int                mlast;
      int                mcnt;
      int                n;
      bit                pending;
      logic              e_valid, e_last, lst;
      logic [DATA_W-1:0] e_data;
      logic [N_SRC-1:0]  e_rdy;
      do_reset();
      for (int s = 0; s < N_SRC; s++) begin
        int npk = $urandom_range(2, 5);
        for (int p = 0; p < npk; p++) begin
          int len = $urandom_range(1, 12);
          for (int b = 0; b < len; b++) push(s, DATA_W'($urandom), b == len - 1);
        end
      end
      mg = 1'b0; mgid = '0; mlast = N_SRC - 1; mcnt = 0; n = 0;
      pending = 1'b1;
      while (pending && n < 2000) begin
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
          logic have;
          have = (head[i] < tail[i]) && ($urandom_range(0, 9) < 8);
          s_tvalid[i] = have;
          s_tdata[i*DATA_W +: DATA_W] = have ? bd[i][head[i]] : '0;
          s_tlast[i] = have ? bl[i][head[i]] : 1'b0;
        end
        m_tready = ($urandom_range(0, 3) != 0);
        #1;
        e_valid = mg && s_tvalid[mgid];
        e_data  = e_valid ? bd[mgid][head[mgid]] : '0;
        e_last  = e_valid ? bl[mgid][head[mgid]] : 1'b0;
        e_rdy   = '0;
        if (mg) e_rdy[mgid] = m_tready;
        tests_run++;
        if (busy !== mg || grant_id !== mgid) begin
          tests_failed++;
          $display("[TB] FAIL rand_grant r%0d c%0d: got busy=%0b gid=%0d, expected busy=%0b gid=%0d",
                   round, n, busy, grant_id, mg, mgid);
        end
        tests_run++;
        if (m_tvalid !== e_valid || m_tlast !== e_last || m_tdata !== e_data || s_tready !== e_rdy) begin
          tests_failed++;
          $display("[TB] FAIL rand_port r%0d c%0d: got v=%0b l=%0b d=%h rdy=%b, expected v=%0b l=%0b d=%h rdy=%b",
                   round, n, m_tvalid, m_tlast, m_tdata, s_tready, e_valid, e_last, e_data, e_rdy);
        end
        if (!mg) begin
          for (int off = 1; off <= N_SRC; off++) begin
            logic [GW-1:0] idx;
            idx = GW'((mlast + off) % N_SRC);
            if (!mg && s_tvalid[idx]) begin
              mg = 1'b1; mgid = idx; mlast = int'(idx); mcnt = 0;
            end
          end
        end else if (e_valid && m_tready) begin
          lst = bl[mgid][head[mgid]];
          head[mgid]++;
          mcnt++;
          if (lst || mcnt == MAX_BURST) mg = 1'b0;
        end
        pending = mg;
        for (int i = 0; i < N_SRC; i++) if (head[i] < tail[i]) pending = 1'b1;
        n++;
      end
      tests_run++;
      if (pending) begin
        tests_failed++;
        $display("[TB] FAIL rand_drain r%0d: traffic still pending after %0d cycles, expected drained", round, n);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    test_reset();
    test_round_robin();
    test_single_packet();
    test_burst_cap();
    test_backpressure();
    test_reset_mid_packet();
    test_valid_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
